// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - sizing helpers and FSM encoding shared by the conv window scheduler
package cnn_pkg;

   // Minimum of 1 so degenerate 1-entry ranges still get a real bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int out_dim(input int img, input int filt);
      return img - filt + 1;
   endfunction

   function automatic int num_out(input int h, input int w, input int filt);
      return out_dim(h, filt) * out_dim(w, filt);
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// rtl/conv_pos_counter.sv - row-major output position walker with window base and flat index
module conv_pos_counter
   import cnn_pkg::*;
#(
   parameter int S = 5,
   parameter int H = 32,
   parameter int W = 32
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         i_clear,
   input  logic                                         i_advance,
   output logic [clog2(out_dim(H, S))-1:0]              o_row,
   output logic [clog2(out_dim(W, S))-1:0]              o_col,
   output logic [clog2(H*W)-1:0]                        o_base,
   output logic [clog2(num_out(H, W, S))-1:0]           o_idx,
   output logic                                         o_last
);
   localparam int RW = clog2(out_dim(H, S));
   localparam int CW = clog2(out_dim(W, S));
   localparam int PW = clog2(H*W);
   localparam int AW = clog2(num_out(H, W, S));
   localparam logic [RW-1:0] ROW_LAST = RW'(out_dim(H, S) - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(out_dim(W, S) - 1);
   // Stepping from the last column of a row to column 0 of the next adds W-OW+1 == S.
   localparam logic [PW-1:0] ROW_STEP = PW'(S);

   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [PW-1:0] r_base;
   logic [AW-1:0] r_idx;

   always_ff @(posedge clk) begin
      if (!rst || i_clear) begin
         r_row  <= '0;
         r_col  <= '0;
         r_base <= '0;
         r_idx  <= '0;
      end else if (i_advance) begin
         r_idx <= r_idx + AW'(1);
         if (r_col == COL_LAST) begin
            r_col  <= '0;
            r_row  <= r_row + RW'(1);
            r_base <= r_base + ROW_STEP;
         end else begin
            r_col  <= r_col + CW'(1);
            r_base <= r_base + PW'(1);
         end
      end
   end

   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_base = r_base;
   assign o_idx  = r_idx;
   assign o_last = (r_row == ROW_LAST) && (r_col == COL_LAST);

endmodule

// File: rtl/conv_window_sched.sv
// rtl/conv_window_sched.sv - sequencer sharing one conv unit across all output positions of a layer
module conv_window_sched
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int D          = 1,
   parameter int S          = 5,
   parameter int H          = 32,
   parameter int W          = 32
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         start,
   output logic                                         busy,
   output logic                                         done,
   output logic                                         req_valid,
   input  logic                                         req_ready,
   output logic [clog2(out_dim(H, S))-1:0]              req_row,
   output logic [clog2(out_dim(W, S))-1:0]              req_col,
   output logic [clog2(H*W)-1:0]                        req_base,
   output logic [clog2(D+1)-1:0]                        req_depth,
   input  logic                                         rsp_valid,
   input  logic [DATA_WIDTH-1:0]                        rsp_data,
   output logic                                         out_we,
   output logic [clog2(num_out(H, W, S))-1:0]           out_addr,
   output logic [DATA_WIDTH-1:0]                        out_data
);
   localparam int AW  = clog2(num_out(H, W, S));
   localparam int DPW = clog2(D+1);

   state_t                r_state;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_req_valid;
   logic [DPW-1:0]        r_req_depth;
   logic                  r_out_we;
   logic [AW-1:0]         r_out_addr;
   logic [DATA_WIDTH-1:0] r_out_data;

   logic                  w_clear;
   logic                  w_take;
   logic                  w_last;
   logic [AW-1:0]         w_idx;

   assign w_clear = (r_state == ST_IDLE) && start;
   assign w_take  = (r_state == ST_WAIT) && rsp_valid;

   conv_pos_counter #(.S(S), .H(H), .W(W)) u_pos (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_clear),
      .i_advance (w_take),
      .o_row     (req_row),
      .o_col     (req_col),
      .o_base    (req_base),
      .o_idx     (w_idx),
      .o_last    (w_last)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_req_valid <= 1'b0;
         r_req_depth <= '0;
         r_out_we    <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
      end else begin
         r_req_depth <= DPW'(D);
         r_out_we    <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_busy <= start;
               if (start) begin
                  r_state     <= ST_ISSUE;
                  r_req_valid <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (rsp_valid) begin
                  // Index is captured before the counter steps on this same edge.
                  r_out_we   <= 1'b1;
                  r_out_addr <= w_idx;
                  r_out_data <= rsp_data;
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_state     <= ST_ISSUE;
                     r_req_valid <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign req_valid = r_req_valid;
   assign req_depth = r_req_depth;
   assign out_we    = r_out_we;
   assign out_addr  = r_out_addr;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_conv_window_sched.sv
// tb/tb_conv_window_sched.sv - scoreboard bench for conv_window_sched (6x6/S3 and 3x3/S3 instances)
module tb_conv_window_sched;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, busy, done, req_valid, req_ready, rsp_valid, out_we;
   logic [1:0]  req_row, req_col, req_depth;
   logic [5:0]  req_base;
   logic [31:0] rsp_data, out_data;
   logic [3:0]  out_addr;

   logic        b_start, b_busy, b_done, b_req_valid, b_req_ready, b_rsp_valid, b_out_we;
   logic [0:0]  b_req_row, b_req_col, b_req_depth, b_out_addr;
   logic [3:0]  b_req_base;
   logic [31:0] b_rsp_data, b_out_data;

   conv_window_sched #(.DATA_WIDTH(32), .D(2), .S(3), .H(6), .W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row), .req_col(req_col),
      .req_base(req_base), .req_depth(req_depth), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
   );

   conv_window_sched #(.DATA_WIDTH(32), .D(1), .S(3), .H(3), .W(3)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_row(b_req_row), .req_col(b_req_col),
      .req_base(b_req_base), .req_depth(b_req_depth), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
      .out_we(b_out_we), .out_addr(b_out_addr), .out_data(b_out_data)
   );

   int  n_checks = 0;
   int  n_fail   = 0;
   int  n_writes = 0;
   int  n_done   = 0;
   wr_t exp_q[$];
   wr_t exp_bq[$];
   bit  stall_en = 1'b0;
   bit  junk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Conv unit model: accepts requests (optionally stalled), answers 2 cycles later
   int          m_k, m_cd, m_stall, m_cur;
   bit          m_hold;
   logic [31:0] m_held;
   initial begin
      m_k = 0; m_cd = -1; m_stall = 0; m_cur = 0; m_hold = 1'b0; m_held = '0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
      forever begin
         @(negedge clk);
         req_ready = 1'b0;
         rsp_valid = 1'b0;
         if (rst !== 1'b1) begin
            m_k = 0; m_cd = -1; m_hold = 1'b0;
            exp_q.delete();
            continue;
         end
         if (m_cd >= 0) begin
            m_cd--;
            if (m_cd == 0) begin
               m_cd      = -1;
               rsp_valid = 1'b1;
               rsp_data  = 32'h100 + 32'(m_cur);
               exp_q.push_back('{32'(m_cur), 32'h100 + 32'(m_cur)});
            end
         end else begin
            if (junk_en) begin
               rsp_valid = 1'b1;
               rsp_data  = 32'hBAD0;
            end
            if (req_valid) begin
               if (!m_hold) begin
                  m_hold  = 1'b1;
                  m_held  = 32'({req_row, req_col, req_base});
                  m_stall = stall_en ? int'($urandom_range(0, 5)) : 0;
               end else begin
                  check("req_held_while_stalled", 32'({req_row, req_col, req_base}), m_held);
               end
               if (m_stall > 0) begin
                  m_stall--;
               end else begin
                  req_ready = 1'b1;
                  m_hold    = 1'b0;
                  m_cd      = 2;
                  m_cur     = m_k;
                  check("req_base", 32'(req_base), 32'((m_k / 4) * 6 + m_k % 4));
                  check("req_row", 32'(req_row), 32'(m_k / 4));
                  check("req_col", 32'(req_col), 32'(m_k % 4));
                  check("req_depth", 32'(req_depth), 32'd2);
                  m_k = (m_k + 1) % 16;
               end
            end
         end
      end
   end

   // Monitor for the 6x6 instance
   initial begin
      bit prev_we, prev_done;
      int pass_w;
      wr_t e;
      prev_we = 1'b0; prev_done = 1'b0; pass_w = 0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) pass_w = 0;
         if (out_we) begin
            n_writes++;
            pass_w++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no response pending", out_addr, out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_addr", 32'(out_addr), e.addr);
               check("out_data", out_data, e.data);
            end
         end
         if (done) begin
            n_done++;
            check("done_after_last_write", 32'(prev_we), 32'd1);
            check("done_single_pulse", 32'(prev_done), 32'd0);
            check("writes_per_pass", 32'(pass_w), 32'd16);
            check("busy_during_done", 32'(busy), 32'd1);
            check("no_req_during_done", 32'(req_valid), 32'd0);
            pass_w = 0;
         end
         if (prev_done && start) check("restart_after_idle_cycle", 32'(req_valid), 32'd1);
         prev_we   = out_we;
         prev_done = done;
      end
   end

   // Monitor for the degenerate 3x3 instance
   int b_nreq = 0;
   int b_ndone = 0;
   initial begin
      bit b_prev_we, b_prev_done;
      wr_t e;
      b_prev_we = 1'b0; b_prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (b_req_valid) b_nreq++;
         if (b_out_we) begin
            n_checks++;
            if (exp_bq.size() == 0) begin
               n_fail++;
               $display("FAIL b_unexpected_write: addr 0x%0h data 0x%0h", b_out_addr, b_out_data);
            end else begin
               e = exp_bq.pop_front();
               check("b_out_addr", 32'(b_out_addr), e.addr);
               check("b_out_data", b_out_data, e.data);
            end
         end
         if (b_done) begin
            b_ndone++;
            check("b_done_after_write", 32'(b_prev_we), 32'd1);
            check("b_busy_with_done", 32'(b_busy), 32'd1);
         end
         if (b_prev_done) check("b_busy_drops", 32'(b_busy), 32'd0);
         b_prev_we   = b_out_we;
         b_prev_done = b_done;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int c;
      c = 0;
      while (n_done < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("pass_completed", 32'(n_done >= target), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      while ((busy || done) && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("returned_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int c, w0, d0;
      rst = 1'b0; start = 1'b0;
      b_start = 1'b0; b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({busy, done, req_valid, out_we, req_row, req_col, req_base, req_depth, out_addr}), 32'd0);
      check("reset_out_data", out_data, 32'd0);
      check("b_reset_outputs", 32'({b_busy, b_done, b_req_valid, b_out_we, b_req_base, b_out_addr}), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // full pass, ready always high
      pulse_start();
      check("busy_after_start", 32'(busy), 32'd1);
      wait_done(1, 400);
      repeat (2) @(negedge clk);
      check("idle_after_pass", 32'({busy, done, req_valid}), 32'd0);
      check("queue_drained_1", 32'(exp_q.size()), 32'd0);

      // random request stalls
      stall_en = 1'b1;
      pulse_start();
      wait_done(2, 800);
      stall_en = 1'b0;
      repeat (2) @(negedge clk);

      // spurious responses and start while busy
      junk_en = 1'b1;
      w0 = n_writes;
      repeat (5) @(negedge clk);
      check("idle_ignores_rsp", 32'({busy, req_valid, out_we}), 32'd0);
      check("idle_no_writes", 32'(n_writes), 32'(w0));
      pulse_start();
      repeat (20) @(negedge clk);
      pulse_start();
      wait_done(3, 400);
      repeat (10) @(negedge clk);
      check("start_while_busy_ignored", 32'({busy, req_valid}), 32'd0);
      check("pass3_done_count", 32'(n_done), 32'd3);
      junk_en = 1'b0;

      // reset in the middle of a pass
      w0 = n_writes;
      d0 = n_done;
      pulse_start();
      c = 0;
      while (n_writes < w0 + 5 && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("fifth_write_seen", 32'(n_writes >= w0 + 5), 32'd1);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_reset_outputs", 32'({busy, done, req_valid, out_we, req_row, req_col, req_base, req_depth, out_addr}), 32'd0);
      check("mid_reset_out_data", out_data, 32'd0);
      #1 rst = 1'b1;
      w0 = n_writes;
      repeat (8) @(negedge clk);
      check("no_resume_after_reset", 32'({busy, req_valid}), 32'd0);
      check("pending_rsp_dropped", 32'(n_writes), 32'(w0));
      check("no_done_after_reset", 32'(n_done), 32'(d0));
      pulse_start();
      wait_done(d0 + 1, 400);
      repeat (2) @(negedge clk);

      // start held high: passes chain with one idle cycle between them
      start = 1'b1;
      wait_done(d0 + 3, 600);
      start = 1'b0;
      wait_idle(400);
      repeat (2) @(negedge clk);
      check("queue_drained_end", 32'(exp_q.size()), 32'd0);

      // degenerate 3x3 image with 3x3 filter
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      c = 0;
      while (!b_req_valid && c < 20) begin
         @(negedge clk);
         c++;
      end
      check("b_req_valid", 32'(b_req_valid), 32'd1);
      check("b_req_pos", 32'({b_req_row, b_req_col, b_req_base}), 32'd0);
      check("b_req_depth", 32'(b_req_depth), 32'd1);
      b_req_ready = 1'b1;
      @(negedge clk);
      b_req_ready = 1'b0;
      @(negedge clk);
      b_rsp_valid = 1'b1;
      b_rsp_data  = 32'hCAFE_0001;
      exp_bq.push_back('{32'd0, 32'hCAFE_0001});
      @(negedge clk);
      b_rsp_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("b_single_request", 32'(b_nreq), 32'd1);
      check("b_single_done", 32'(b_ndone), 32'd1);
      check("b_queue_drained", 32'(exp_bq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
